game_input_conditioner: RTL
===========================

// Module: game_input_conditioner
// PURPOSE
//  Upstream stage of the game core. Takes the three raw active-low push buttons
//  (left, right, reset) and synchronises and debounces each one. It also
//  generates the game tick from CLK_50.
//  Once per tick it presents one registered command set (left/right/restart)
//  to the game logic. Presses shorter than a tick period are latched, not lost.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000    consecutive stable CLK_50 cycles before a level change is accepted (10 ms)
//  TICK_DIV         20000000  CLK_50 cycles per game tick (2.5 Hz)
//  HOLD_REPEAT      1         1: a button held at tick time issues its command every tick; 0: press edges only
// PORTS
//  CLK_50        in   1  system clock, 50 MHz
//  RESET         in   1  synchronous, active-high reset
//  button_left   in   1  raw button, active-low, asynchronous
//  button_right  in   1  raw button, active-low, asynchronous
//  button_reset  in   1  raw button, active-low, asynchronous
//  game_tick     out  1  one-cycle strobe; command outputs are valid only in this cycle
//  cmd_left      out  1  move player left this tick
//  cmd_right     out  1  move player right this tick
//  cmd_restart   out  1  restart game this tick
//  btn_level     out  3  debounced pressed level {reset,right,left}, 1 = pressed (LED debug)
// BEHAVIOUR
//  Reset (RESET=1 at a CLK_50 edge):
//   - sync flops=1, debounced stable=1 (released), debounce counters=0, tick counter=0
//   - pending latches=0; game_tick, cmd_*=0; btn_level=0
//   - reset mid-operation discards all pending presses
//  Sync: 2-flop synchroniser per button. No raw input is used before the second flop.
//  Debounce, per button:
//   - sync==stable -> counter=0
//   - otherwise counter+1; when counter reaches DEBOUNCE_CYCLES-1, stable<=sync and counter=0
//   - a glitch shorter than DEBOUNCE_CYCLES cycles never changes stable
//   - counter width $clog2(DEBOUNCE_CYCLES)
//  Press event: one-cycle pulse on a stable 1->0 transition. Release produces no event.
//  Pending latch, per button:
//   - set by a press event; cleared in the cycle the internal tick fires
//   - press and tick in the same cycle: latch ends 1, so the press is served at the next tick, never dropped
//   - multiple presses between ticks collapse to one command
//  Tick counter: counts 0..TICK_DIV-1 and wraps to 0. Internal tick = (count==TICK_DIV-1).
//  Output register (1-cycle latency after the internal tick):
//   - req_x = pending_x | (HOLD_REPEAT & ~stable_x)
//   - game_tick <= 1 for exactly one cycle, otherwise 0
//   - cmd_restart <= req_reset
//   - cmd_right <= req_right & ~req_reset
//   - cmd_left <= req_left & ~req_right & ~req_reset
//   - priority: restart > right > left; at most one cmd bit is high
//   - cmd_* are 0 in every cycle where game_tick=0
//  btn_level is registered ~stable and updates one cycle after stable.
//  No FSM beyond counters; the per-button state is {sync[1:0], stable, count, pending}.
// STRUCTURE
//  Shared package game_pkg:
//   - BTN_LEFT=0, BTN_RIGHT=1, BTN_RESET=2, NUM_BTN=3
//   - default TICK_DIV, which the game core also uses for its timing constants
//  Sub-module button_debounce (sync + debounce + press pulse), parameter DEBOUNCE_CYCLES,
//  instantiated NUM_BTN times.
//  Top level holds the tick counter, pending latches and output/priority register.
// TESTING  (bench parameters: DEBOUNCE_CYCLES=4, TICK_DIV=16, HOLD_REPEAT=0 unless stated)
//  1 RESET high 3 cycles, buttons at 1 -> all outputs 0; first game_tick at cycle 16 after reset release (cycle 1 = first non-reset edge).
//  2 button_left low for 3 cycles, then high -> btn_level stays 000; no cmd_left at the next tick (glitch rejected).
//  3 button_left low for 6 cycles, released well before the tick -> btn_level[0] pulses; next game_tick has cmd_left=1; following tick cmd_left=0.
//  4 Press event timed on the internal-tick cycle -> that tick's cmd_right=0; next tick cmd_right=1.
//  5 Left and right both pending -> cmd_right=1, cmd_left=0. Add a reset press -> cmd_restart=1, both moves 0.
//  6 HOLD_REPEAT=1, right held 5 ticks -> cmd_right=1 on all 5. RESET mid-hold with a pending left -> no command after reset until a new press.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg
//   Constants shared by the game core: button indices into the per-button
//   vectors, default timing, and a counter-width helper.
//   No ports (package).
package game_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_RESET = 2;
  localparam int NUM_BTN   = 3;

  // 2.5 Hz game tick from the 50 MHz system clock; the game core derives its
  // own timing constants from this value.
  localparam int TICK_DIV_DEFAULT = 20_000_000;

  // 10 ms of stable input at 50 MHz.
  localparam int DEBOUNCE_DEFAULT = 500_000;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
//   Two-flop synchroniser, level debouncer and press detector for one raw
//   active-low push button.
// Ports
//   clock   in   1  system clock
//   reset   in   1  synchronous, active-high
//   raw     in   1  asynchronous raw button, 0 = pressed
//   stable  out  1  debounced level, 0 = pressed, 1 after reset
//   press   out  1  one-cycle pulse in the cycle before stable falls 1->0
module button_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] count;
  logic          accept;

  // The synchronised level has disagreed with stable for DEBOUNCE_CYCLES
  // consecutive cycles including this one, so stable takes it at the edge.
  assign accept = (sync[1] != stable) && (count == LAST);

  // Only a released->pressed acceptance is an event; releases are silent.
  // The pulse coincides with the acceptance, so the pending latch sets on the
  // same edge that stable goes low.
  assign press = accept && stable;

  // Only sync[1] is ever looked at; sync[0] may go metastable.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      count  <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == stable) begin
        count <= '0;
      end else if (accept) begin
        stable <= sync[1];
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_input_conditioner.sv
// game_input_conditioner
//   Conditions the three raw game buttons and, once per game tick, presents a
//   single prioritised command (restart > right > left) to the game logic.
//   Presses shorter than a tick are latched and served at the next tick.
// Ports
//   CLK_50        in   1  system clock, 50 MHz
//   RESET         in   1  synchronous, active-high
//   button_left   in   1  raw button, active-low, asynchronous
//   button_right  in   1  raw button, active-low, asynchronous
//   button_reset  in   1  raw button, active-low, asynchronous
//   game_tick     out  1  one-cycle strobe; cmd_* valid only in this cycle
//   cmd_left      out  1  move player left this tick
//   cmd_right     out  1  move player right this tick
//   cmd_restart   out  1  restart game this tick
//   btn_level     out  3  debounced pressed level {reset,right,left}, 1 = pressed
module game_input_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int TICK_DIV        = TICK_DIV_DEFAULT,
  parameter bit HOLD_REPEAT     = 1'b1
) (
  input  logic               CLK_50,
  input  logic               RESET,
  input  logic               button_left,
  input  logic               button_right,
  input  logic               button_reset,
  output logic               game_tick,
  output logic               cmd_left,
  output logic               cmd_right,
  output logic               cmd_restart,
  output logic [NUM_BTN-1:0] btn_level
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  btn_vec_t      raw;
  btn_vec_t      stable;
  btn_vec_t      press;
  btn_vec_t      pending;
  btn_vec_t      req;
  logic [TW-1:0] tick_count;
  logic          tick;

  assign raw[BTN_LEFT]  = button_left;
  assign raw[BTN_RIGHT] = button_right;
  assign raw[BTN_RESET] = button_reset;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock (CLK_50),
      .reset (RESET),
      .raw   (raw[b]),
      .stable(stable[b]),
      .press (press[b])
    );
  end

  assign tick = (tick_count == TICK_LAST);

  always_ff @(posedge CLK_50) begin
    if (RESET || tick) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + 1'b1;
    end
  end

  // Press wins over the tick clear: a press landing on the tick cycle was not
  // part of this tick's request, so it must survive to the next one.
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      pending <= '0;
    end else begin
      pending <= press | (pending & ~{NUM_BTN{tick}});
    end
  end

  assign req = pending | ({NUM_BTN{HOLD_REPEAT}} & ~stable);

  // Gating every command with tick keeps cmd_* at zero between strobes.
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      game_tick   <= 1'b0;
      cmd_restart <= 1'b0;
      cmd_right   <= 1'b0;
      cmd_left    <= 1'b0;
      btn_level   <= '0;
    end else begin
      game_tick   <= tick;
      cmd_restart <= tick & req[BTN_RESET];
      cmd_right   <= tick & req[BTN_RIGHT] & ~req[BTN_RESET];
      cmd_left    <= tick & req[BTN_LEFT] & ~req[BTN_RIGHT] & ~req[BTN_RESET];
      btn_level   <= ~stable;
    end
  end

endmodule
